// File: rtl/vjtag_gpio_regs_pkg.sv
// Shared register map, edge-mode encoding and per-channel command payload
// for the vjtag_host GPIO register slave.
package vjtag_gpio_pkg;

    localparam int unsigned CH_STRIDE = 8;
    localparam int unsigned REG_AW    = 3;

    localparam logic [REG_AW-1:0] REG_IN   = 3'd0;
    localparam logic [REG_AW-1:0] REG_OUT  = 3'd1;
    localparam logic [REG_AW-1:0] REG_SET  = 3'd2;
    localparam logic [REG_AW-1:0] REG_CLR  = 3'd3;
    localparam logic [REG_AW-1:0] REG_TGL  = 3'd4;
    localparam logic [REG_AW-1:0] REG_EDGE = 3'd5;
    localparam logic [REG_AW-1:0] REG_MASK = 3'd6;
    localparam logic [REG_AW-1:0] REG_MODE = 3'd7;

    typedef enum logic [1:0] {
        MODE_RISE = 2'd0,
        MODE_FALL = 2'd1,
        MODE_BOTH = 2'd2,
        MODE_NONE = 2'd3
    } mode_e;

    // Decoded per-channel access: write enable plus register select.
    typedef struct packed {
        logic              en;
        logic [REG_AW-1:0] sel;
    } ch_cmd_t;

    function automatic logic edge_hit(input mode_e mode, input logic prev, input logic cur);
        logic hit;
        hit = 1'b0;
        case (mode)
            MODE_RISE: hit = cur & ~prev;
            MODE_FALL: hit = prev & ~cur;
            MODE_BOTH: hit = prev ^ cur;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/vjtag_gpio_regs_channel.sv
// One GPIO channel: input synchroniser, edge capture and the OUT/EDGE/MASK/MODE
// registers, with a combinational read mux and interrupt term for the top.
module gpio_channel
    import vjtag_gpio_pkg::*;
#(
    parameter int unsigned   DW          = 16,
    parameter int unsigned   SYNC_STAGES = 2,
    parameter logic [DW-1:0] OUT_RESET   = '1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          soft_rst_n,
    input  logic          arm,
    input  ch_cmd_t       cmd,
    input  logic [DW-1:0] wdata,
    input  logic [DW-1:0] gpio_in,
    output logic [DW-1:0] gpio_out,
    output logic [DW-1:0] rd_data_c,
    output logic          irq_term_c
);

    logic [DW-1:0] sync_q [SYNC_STAGES];
    logic [DW-1:0] in_w;
    logic [DW-1:0] prev_q;
    logic [DW-1:0] edge_q;
    logic [DW-1:0] mask_q;
    mode_e         mode_q;

    logic [DW-1:0] hit_c;
    logic [DW-1:0] clr_c;
    logic [DW-1:0] out_d;
    logic [DW-1:0] edge_d;
    logic [DW-1:0] mask_d;
    mode_e         mode_d;

    assign in_w = sync_q[SYNC_STAGES-1];

    // Synchroniser chain and one-cycle-delayed copy of the synchronised input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q <= '0;
        end else if (!soft_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= in_w;
        end
    end

    // Edge detection is suppressed until the top says the pipeline is filled.
    always_comb begin
        hit_c = '0;
        for (int b = 0; b < DW; b++) hit_c[b] = edge_hit(mode_q, prev_q[b], in_w[b]);
        if (!arm) hit_c = '0;
    end

    always_comb begin
        out_d  = gpio_out;
        mask_d = mask_q;
        mode_d = mode_q;
        clr_c  = '0;
        if (cmd.en) begin
            case (cmd.sel)
                REG_OUT:  out_d  = wdata;
                REG_SET:  out_d  = gpio_out | wdata;
                REG_CLR:  out_d  = gpio_out & ~wdata;
                REG_TGL:  out_d  = gpio_out ^ wdata;
                REG_EDGE: clr_c  = wdata;
                REG_MASK: mask_d = wdata;
                REG_MODE: mode_d = mode_e'(wdata[1:0]);
                default:  ;
            endcase
        end
        // A fresh edge wins over a same-cycle W1C on the same bit.
        edge_d = (edge_q & ~clr_c) | hit_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_out <= OUT_RESET;
            edge_q   <= '0;
            mask_q   <= '0;
            mode_q   <= MODE_RISE;
        end else if (!soft_rst_n) begin
            gpio_out <= OUT_RESET;
            edge_q   <= '0;
            mask_q   <= '0;
            mode_q   <= MODE_RISE;
        end else begin
            gpio_out <= out_d;
            edge_q   <= edge_d;
            mask_q   <= mask_d;
            mode_q   <= mode_d;
        end
    end

    always_comb begin
        rd_data_c = '0;
        case (cmd.sel)
            REG_IN:   rd_data_c = in_w;
            REG_OUT:  rd_data_c = gpio_out;
            REG_EDGE: rd_data_c = edge_q;
            REG_MASK: rd_data_c = mask_q;
            REG_MODE: rd_data_c = DW'(mode_q);
            default:  rd_data_c = '0;
        endcase
    end

    assign irq_term_c = |(edge_q & mask_q);

endmodule

// File: rtl/vjtag_gpio_regs.sv
// Multi-channel GPIO register slave on the vjtag_host simple bus: address
// decode, registered read path, edge-capture arming and the interrupt OR.
module vjtag_gpio_regs
    import vjtag_gpio_pkg::*;
#(
    parameter int unsigned   AW          = 16,
    parameter int unsigned   DW          = 16,
    parameter int unsigned   NCH         = 2,
    parameter int unsigned   BASE        = 0,
    parameter int unsigned   SYNC_STAGES = 2,
    parameter logic [DW-1:0] OUT_RESET   = '1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              soft_rst_n,
    input  logic [AW-1:0]     address,
    input  logic              wvalid,
    input  logic [DW-1:0]     wdata,
    output logic              wready,
    input  logic              rvalid,
    output logic              rready,
    output logic              rrvalid,
    output logic [DW-1:0]     rdata,
    input  logic [NCH*DW-1:0] gpio_in,
    output logic [NCH*DW-1:0] gpio_out,
    output logic              irq
);

    localparam int unsigned NREG    = NCH * CH_STRIDE;
    localparam int unsigned CW      = AW - REG_AW;
    localparam int unsigned ARM_CNT = SYNC_STAGES + 1;
    localparam int unsigned ACW     = $clog2(ARM_CNT + 1);

    logic [AW-1:0]     off_c;
    logic              in_range_c;
    logic              id_hit_c;
    logic [CW-1:0]     ch_c;
    logic [REG_AW-1:0] sel_c;
    logic [DW-1:0]     rd_data_c;
    logic [ACW-1:0]    arm_cnt;
    logic              arm_c;

    ch_cmd_t       ch_cmd [NCH];
    logic [DW-1:0] ch_rd  [NCH];
    logic [NCH-1:0] ch_irq;

    assign wready = 1'b1;
    assign rready = 1'b1;

    // Offsets below BASE wrap to large values and therefore decode as unmapped.
    assign off_c      = address - AW'(BASE);
    assign in_range_c = off_c < AW'(NREG);
    assign id_hit_c   = off_c == AW'(NREG);
    assign ch_c       = off_c[AW-1:REG_AW];
    assign sel_c      = off_c[REG_AW-1:0];

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        localparam logic [CW-1:0] CH_IDX = CW'(c);

        assign ch_cmd[c] = '{en:  wvalid && soft_rst_n && in_range_c && (ch_c == CH_IDX),
                             sel: sel_c};

        gpio_channel #(
            .DW          (DW),
            .SYNC_STAGES (SYNC_STAGES),
            .OUT_RESET   (OUT_RESET)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .soft_rst_n (soft_rst_n),
            .arm        (arm_c),
            .cmd        (ch_cmd[c]),
            .wdata      (wdata),
            .gpio_in    (gpio_in[c*DW +: DW]),
            .gpio_out   (gpio_out[c*DW +: DW]),
            .rd_data_c  (ch_rd[c]),
            .irq_term_c (ch_irq[c])
        );
    end

    always_comb begin
        rd_data_c = '0;
        if (id_hit_c) rd_data_c = DW'(NCH);
        for (int c = 0; c < NCH; c++) begin
            if (in_range_c && (ch_c == CW'(c))) rd_data_c = ch_rd[c];
        end
    end

    // Edge capture stays off until the synchroniser and prev stage hold real input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_cnt <= '0;
        end else if (!soft_rst_n) begin
            arm_cnt <= '0;
        end else if (arm_cnt != ACW'(ARM_CNT)) begin
            arm_cnt <= arm_cnt + ACW'(1);
        end
    end

    assign arm_c = arm_cnt == ACW'(ARM_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrvalid <= 1'b0;
            rdata   <= '0;
            irq     <= 1'b0;
        end else if (!soft_rst_n) begin
            rrvalid <= 1'b0;
            rdata   <= '0;
            irq     <= 1'b0;
        end else begin
            rrvalid <= rvalid;
            if (rvalid) rdata <= rd_data_c;
            irq <= |ch_irq;
        end
    end

endmodule

// File: tb/tb_vjtag_gpio_regs.sv
// Self-checking bench for vjtag_gpio_regs (NCH=2, DW=16, BASE=0, SYNC_STAGES=2).
module tb_vjtag_gpio_regs;

    localparam int unsigned AW  = 16;
    localparam int unsigned DW  = 16;
    localparam int unsigned NCH = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              soft_rst_n;
    logic [AW-1:0]     address;
    logic              wvalid;
    logic [DW-1:0]     wdata;
    logic              wready;
    logic              rvalid;
    logic              rready;
    logic              rrvalid;
    logic [DW-1:0]     rdata;
    logic [NCH*DW-1:0] gpio_in;
    logic [NCH*DW-1:0] gpio_out;
    logic              irq;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] exp;
    } rd_exp_t;

    typedef struct {
        logic        is_rd;
        logic [15:0] addr;
        logic [15:0] data;
        logic [31:0] exp_out;
        logic [15:0] exp_rd;
        string       name;
    } vec_t;

    rd_exp_t sb_q[$];
    vec_t    vecs[$];

    vjtag_gpio_regs dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .soft_rst_n (soft_rst_n),
        .address    (address),
        .wvalid     (wvalid),
        .wdata      (wdata),
        .wready     (wready),
        .rvalid     (rvalid),
        .rready     (rready),
        .rrvalid    (rrvalid),
        .rdata      (rdata),
        .gpio_in    (gpio_in),
        .gpio_out   (gpio_out),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000 ns, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Read-data scoreboard: every rrvalid pulse must match the oldest issued read.
    always @(negedge clk) begin
        rd_exp_t e;
        if (rrvalid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rrvalid: got pulse rdata 0x%04h want no pulse", rdata);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("read@%0d", e.addr), 32'(rdata), 32'(e.exp));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        address = a;
        wdata   = d;
        wvalid  = 1'b1;
        tick();
        wvalid  = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, input logic [15:0] exp);
        rd_exp_t e;
        e.addr  = a;
        e.exp   = exp;
        sb_q.push_back(e);
        address = a;
        rvalid  = 1'b1;
        tick();
        rvalid  = 1'b0;
    endtask

    function automatic vec_t mk(input logic is_rd, input logic [15:0] a, input logic [15:0] d,
                                input logic [31:0] eo, input logic [15:0] er, input string n);
        vec_t v;
        v.is_rd = is_rd; v.addr = a; v.data = d; v.exp_out = eo; v.exp_rd = er; v.name = n;
        return v;
    endfunction

    initial begin
        rst_n = 1'b0; soft_rst_n = 1'b1; address = '0; wvalid = 1'b0;
        wdata = '0; rvalid = 1'b0; gpio_in = '0;

        // Reset values and ID register.
        tick(); tick();
        check("rst_gpio_out", gpio_out, 32'hFFFF_FFFF);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_rrvalid", 32'(rrvalid), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("wready", 32'(wready), 32'd1);
        check("rready", 32'(rready), 32'd1);
        rst_n = 1'b1;
        tick();
        bus_read(16, 16'h0002);
        tick();
        check("rrvalid_one_cycle", 32'(rrvalid), 32'd0);
        check("rdata_hold", 32'(rdata), 32'h0002);

        // Output operations and register readback.
        vecs.push_back(mk(0,  1, 16'h1234, 32'hFFFF_1234, 16'h0000, "wr_out"));
        vecs.push_back(mk(0,  2, 16'h00F0, 32'hFFFF_12F4, 16'h0000, "wr_set"));
        vecs.push_back(mk(0,  3, 16'h0204, 32'hFFFF_10F0, 16'h0000, "wr_clr"));
        vecs.push_back(mk(0,  4, 16'hFFFF, 32'hFFFF_EF0F, 16'h0000, "wr_tgl"));
        vecs.push_back(mk(1,  1, 16'h0000, 32'hFFFF_EF0F, 16'hEF0F, "rd_out"));
        vecs.push_back(mk(1,  2, 16'h0000, 32'hFFFF_EF0F, 16'h0000, "rd_set"));
        vecs.push_back(mk(1,  3, 16'h0000, 32'hFFFF_EF0F, 16'h0000, "rd_clr"));
        vecs.push_back(mk(1,  4, 16'h0000, 32'hFFFF_EF0F, 16'h0000, "rd_tgl"));
        vecs.push_back(mk(0,  9, 16'hA5A5, 32'hA5A5_EF0F, 16'h0000, "wr_out1"));
        vecs.push_back(mk(0, 10, 16'h0F00, 32'hAFA5_EF0F, 16'h0000, "wr_set1"));
        vecs.push_back(mk(1,  9, 16'h0000, 32'hAFA5_EF0F, 16'hAFA5, "rd_out1"));
        vecs.push_back(mk(1,  0, 16'h0000, 32'hAFA5_EF0F, 16'h0000, "rd_in0"));
        vecs.push_back(mk(0,  6, 16'h00FF, 32'hAFA5_EF0F, 16'h0000, "wr_mask"));
        vecs.push_back(mk(1,  6, 16'h0000, 32'hAFA5_EF0F, 16'h00FF, "rd_mask"));
        vecs.push_back(mk(0,  7, 16'hFFFE, 32'hAFA5_EF0F, 16'h0000, "wr_mode"));
        vecs.push_back(mk(1,  7, 16'h0000, 32'hAFA5_EF0F, 16'h0002, "rd_mode"));
        foreach (vecs[i]) begin
            if (vecs[i].is_rd) bus_read(vecs[i].addr, vecs[i].exp_rd);
            else               bus_write(vecs[i].addr, vecs[i].data);
            check({vecs[i].name, "_gpio_out"}, gpio_out, vecs[i].exp_out);
        end

        // Read and write on the same cycle: read returns the pre-write value.
        sb_q.push_back('{addr: 16'd1, exp: 16'hEF0F});
        address = 1; wdata = 16'h0F0F; wvalid = 1'b1; rvalid = 1'b1;
        tick();
        wvalid = 1'b0; rvalid = 1'b0;
        check("rw_gpio_out", gpio_out, 32'hAFA5_0F0F);

        // Soft reset; the bus access in that cycle is ignored (no read pulse).
        soft_rst_n = 1'b0;
        address = 1; wdata = 16'h1111; wvalid = 1'b1; rvalid = 1'b1;
        tick();
        soft_rst_n = 1'b1; wvalid = 1'b0; rvalid = 1'b0;
        check("soft_gpio_out", gpio_out, 32'hFFFF_FFFF);
        check("soft_rdata", 32'(rdata), 32'd0);
        bus_read(6, 16'h0000);
        bus_read(7, 16'h0000);
        bus_read(5, 16'h0000);

        // Rising edge on channel 1 bit 0 with interrupt masked in.
        bus_write(14, 16'h0001);
        bus_write(15, 16'h0000);
        gpio_in[16] = 1'b1;
        tick();
        bus_read(8, 16'h0000);
        bus_read(8, 16'h0001);
        check("edge_irq_not_yet", 32'(irq), 32'd0);
        bus_read(13, 16'h0001);
        check("edge_irq_set", 32'(irq), 32'd1);
        bus_write(13, 16'h0001);
        tick();
        check("w1c_irq_clear", 32'(irq), 32'd0);
        bus_read(13, 16'h0000);

        // Collision: W1C lands on the cycle a new edge is detected (MODE=both).
        bus_write(15, 16'h0002);
        gpio_in[16] = 1'b0;
        repeat (5) tick();
        check("fall_irq", 32'(irq), 32'd1);
        gpio_in[16] = 1'b1;
        tick(); tick();
        bus_write(13, 16'h0001);
        tick();
        check("collide_irq", 32'(irq), 32'd1);
        bus_read(13, 16'h0001);
        bus_write(13, 16'h0001);
        tick(); tick();
        check("collide_clear_irq", 32'(irq), 32'd0);

        // Inputs already high across reset release must not create edges.
        gpio_in = 32'h0001_FFFF;
        rst_n = 1'b0;
        tick();
        check("arm_rst_gpio_out", gpio_out, 32'hFFFF_FFFF);
        check("arm_rst_rdata", 32'(rdata), 32'd0);
        rst_n = 1'b1;
        bus_write(6, 16'hFFFF);
        bus_write(14, 16'h0001);
        repeat (4) tick();
        bus_read(5, 16'h0000);
        bus_read(13, 16'h0000);
        bus_read(0, 16'hFFFF);
        check("arm_irq", 32'(irq), 32'd0);

        // Async reset while a read is in flight kills the pulse immediately.
        bus_write(1, 16'h5555);
        check("pre_hrst_gpio_out", gpio_out, 32'hFFFF_5555);
        address = 1; rvalid = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("hrst_async_gpio_out", gpio_out, 32'hFFFF_FFFF);
        rvalid = 1'b0;
        tick();
        check("hrst_rrvalid", 32'(rrvalid), 32'd0);
        check("hrst_rdata", 32'(rdata), 32'd0);
        rst_n = 1'b1;
        tick();
        check("hrst_rrvalid_after", 32'(rrvalid), 32'd0);

        // Unmapped and read-only addresses.
        bus_read(17, 16'h0000);
        bus_write(17, 16'h0000);
        bus_write(16, 16'h0000);
        bus_write(16'h0101, 16'h0000);
        check("unmapped_wr_gpio_out", gpio_out, 32'hFFFF_FFFF);
        bus_read(1, 16'hFFFF);
        bus_read(16, 16'h0002);
        bus_read(16'h0100, 16'h0000);
        bus_read(16'hFFFF, 16'h0000);
        tick(); tick();

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
